// File: rtl/sccomp_run_monitor_if.sv
// Dump stream port of the sccomp run monitor: one word per valid&&ready beat,
// halt PC first, then r0..r(NREG-1).
interface sccomp_run_monitor_if #(
   parameter int RSEL_W = 5
);
   logic              dump_valid;
   logic              dump_ready;
   logic [31:0]       dump_data;
   logic [RSEL_W:0]   dump_idx;
   logic              dump_last;

   modport master (
      output dump_valid, dump_data, dump_idx, dump_last,
      input  dump_ready
   );

   modport slave (
      input  dump_valid, dump_data, dump_idx, dump_last,
      output dump_ready
   );
endinterface

// File: rtl/sccomp_run_monitor.sv
// Run controller for sccomp: gates the CPU, halts on a PC breakpoint or cycle
// budget, then streams halt PC and the register file out over the dump port.
module sccomp_run_monitor #(
   parameter int NBP        = 4,
   parameter int MAX_CYCLES = 1000,
   parameter int CNT_W      = 16,
   parameter int NREG       = 32,
   parameter int RSEL_W     = 5,
   localparam int BPW       = (NBP > 1) ? $clog2(NBP) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start_i,
   input  logic                 clear_i,
   input  logic [31:0]          pc_i,
   input  logic [NBP*32-1:0]    bp_addr_i,
   input  logic [NBP-1:0]       bp_en_i,
   input  logic [31:0]          reg_data_i,
   output logic                 cpu_run_o,
   output logic [RSEL_W-1:0]    reg_sel_o,
   output logic                 done_o,
   output logic [1:0]           halt_cause_o,
   output logic [BPW-1:0]       halt_bp_id_o,
   output logic [CNT_W-1:0]     cycle_count_o,
   sccomp_run_monitor_if.master dump
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP, S_DONE} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
   localparam logic [RSEL_W:0]  LAST_IDX = (RSEL_W+1)'(NREG);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RSEL_W:0]     idx_q, idx_d;
   logic [31:0]         hpc_q, hpc_d;
   logic [1:0]          cause_q, cause_d;
   logic [BPW-1:0]      bpid_q, bpid_d;
   logic                hit, tmo, valid;
   logic [BPW-1:0]      hit_id;

   // Descending scan so the lowest matching comparator wins.
   always_comb begin
      hit    = 1'b0;
      hit_id = '0;
      for (int k = NBP-1; k >= 0; k--) begin
         if (bp_en_i[k] && (pc_i == bp_addr_i[32*k +: 32])) begin
            hit    = 1'b1;
            hit_id = BPW'(k);
         end
      end
   end

   assign tmo = (cnt_q == MAX_CNT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      hpc_d     = hpc_q;
      cause_d   = cause_q;
      bpid_d    = bpid_q;
      cpu_run_o = 1'b0;
      valid     = 1'b0;
      done_o    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
               cnt_d   = '0;
               cause_d = 2'b00;
               idx_d   = '0;
               bpid_d  = '0;
            end
         end
         S_RUN: begin
            // Breakpoint takes priority; the instruction at the halt PC never executes.
            if (hit || tmo) begin
               state_d = S_DUMP;
               hpc_d   = pc_i;
               cause_d = hit ? 2'b01 : 2'b10;
               bpid_d  = hit ? hit_id : '0;
            end else begin
               cpu_run_o = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         S_DUMP: begin
            valid = 1'b1;
            if (dump.dump_ready) begin
               if (idx_q == LAST_IDX) state_d = S_DONE;
               else                   idx_d   = idx_q + (RSEL_W+1)'(1);
            end
         end
         S_DONE: begin
            done_o = 1'b1;
            if (clear_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         hpc_q   <= '0;
         cause_q <= 2'b00;
         bpid_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         hpc_q   <= hpc_d;
         cause_q <= cause_d;
         bpid_q  <= bpid_d;
      end
   end

   // Word 0 is the halt PC, so register r(i-1) is presented at index i.
   assign reg_sel_o       = (state_q == S_DUMP && idx_q != '0) ?
                            RSEL_W'(idx_q - (RSEL_W+1)'(1)) : '0;
   assign dump.dump_valid = valid;
   assign dump.dump_idx   = idx_q;
   assign dump.dump_data  = (idx_q == '0) ? hpc_q : reg_data_i;
   assign dump.dump_last  = valid && (idx_q == LAST_IDX);
   assign halt_cause_o    = cause_q;
   assign halt_bp_id_o    = bpid_q;
   assign cycle_count_o   = cnt_q;

endmodule

// File: tb/tb_sccomp_run_monitor.sv
// Bench for sccomp_run_monitor: a toy CPU walks a PC sequence while cpu_run is
// high; a reference model predicts halt point, cause and dump contents.
module tb_sccomp_run_monitor;
   localparam int NBP = 4;
   localparam int NREG = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rstn, start_a, start_b, clear, cpu_rst;
   logic [NBP*32-1:0] bp_addr;
   logic [NBP-1:0]    bp_en;
   logic [31:0]       rf [NREG];
   logic [31:0]       pc_base;
   int                loop_len;
   int                step_a, step_b;
   int                total = 0, bad = 0;

   logic [31:0] pc_a, pc_b, rdata_a, rdata_b;
   logic        cpu_run_a, cpu_run_b, done_a, done_b;
   logic [4:0]  rsel_a, rsel_b;
   logic [1:0]  cause_a, cause_b;
   logic [1:0]  bpid_a, bpid_b;
   logic [15:0] cnt_a, cnt_b;

   sccomp_run_monitor_if #(.RSEL_W(5)) if_a ();
   sccomp_run_monitor_if #(.RSEL_W(5)) if_b ();

   sccomp_run_monitor #(.MAX_CYCLES(1000)) u_dut (
      .clk(clk), .rstn(rstn), .start_i(start_a), .clear_i(clear), .pc_i(pc_a),
      .bp_addr_i(bp_addr), .bp_en_i(bp_en), .reg_data_i(rdata_a),
      .cpu_run_o(cpu_run_a), .reg_sel_o(rsel_a), .done_o(done_a),
      .halt_cause_o(cause_a), .halt_bp_id_o(bpid_a), .cycle_count_o(cnt_a),
      .dump(if_a.master));

   sccomp_run_monitor #(.MAX_CYCLES(5)) u_dut5 (
      .clk(clk), .rstn(rstn), .start_i(start_b), .clear_i(clear), .pc_i(pc_b),
      .bp_addr_i(bp_addr), .bp_en_i(bp_en), .reg_data_i(rdata_b),
      .cpu_run_o(cpu_run_b), .reg_sel_o(rsel_b), .done_o(done_b),
      .halt_cause_o(cause_b), .halt_bp_id_o(bpid_b), .cycle_count_o(cnt_b),
      .dump(if_b.master));

   // Toy CPU: PC is base + 4*step (optionally looping); step advances when enabled.
   assign pc_a    = (loop_len == 0) ? pc_base + 32'(4*step_a) : pc_base + 32'(4*(step_a % loop_len));
   assign pc_b    = (loop_len == 0) ? pc_base + 32'(4*step_b) : pc_base + 32'(4*(step_b % loop_len));
   assign rdata_a = rf[rsel_a];
   assign rdata_b = rf[rsel_b];

   always @(posedge clk) begin
      if (cpu_rst) begin
         step_a <= 0;
         step_b <= 0;
      end else begin
         if (cpu_run_a) step_a <= step_a + 1;
         if (cpu_run_b) step_b <= step_b + 1;
      end
   end

   function automatic logic [31:0] pcf(input int s);
      return (loop_len == 0) ? pc_base + 32'(4*s) : pc_base + 32'(4*(s % loop_len));
   endfunction

   // Reference: first instruction index n whose PC hits an enabled bp, else the budget.
   function automatic void model(input int maxc, output int cnt, output int cause,
                                 output int id, output logic [31:0] hpc);
      bit found;
      cause = 2; cnt = maxc; id = 0; hpc = pcf(maxc);
      for (int n = 0; n <= maxc; n++) begin
         found = 0;
         for (int k = 0; k < NBP; k++) begin
            if (!found && bp_en[k] && bp_addr[32*k +: 32] == pcf(n)) begin
               found = 1; id = k;
            end
         end
         if (found) begin
            cause = 1; cnt = n; hpc = pcf(n);
            return;
         end
      end
   endfunction

   function automatic logic [31:0] exp_word(input int k, input logic [31:0] hpc);
      return (k == 0) ? hpc : rf[k-1];
   endfunction

   task automatic randomize_rf();
      for (int i = 0; i < NREG; i++) rf[i] = $urandom;
   endtask

   task automatic launch(input bit use_b);
      @(negedge clk); cpu_rst = 1;
      @(negedge clk); cpu_rst = 0;
      if (use_b) start_b = 1; else start_a = 1;
      @(negedge clk); start_a = 0; start_b = 0;
   endtask

   task automatic wait_dump_a();
      for (int n = 0; n < 3000 && !if_a.dump_valid; n++) @(negedge clk);
      total++;
      if (if_a.dump_valid !== 1'b1) begin
         bad++; $display("FAIL wait_dump: dump_valid=%0b need 1 within budget", if_a.dump_valid);
      end
   endtask

   task automatic drain_a();
      if_a.dump_ready = 1;
      for (int n = 0; n < 200 && !done_a; n++) @(negedge clk);
      if_a.dump_ready = 0;
      total++;
      if (done_a !== 1'b1) begin bad++; $display("FAIL drain: done=%0b need 1", done_a); end
   endtask

   task automatic pulse_clear();
      clear = 1; @(negedge clk); clear = 0;
   endtask

   task automatic test_reset();
      @(negedge clk); rstn = 0; cpu_rst = 1;
      @(negedge clk); rstn = 1; cpu_rst = 0;
      total += 7;
      if (cpu_run_a !== 0)        begin bad++; $display("FAIL rst_cpu_run: got %0b need 0", cpu_run_a); end
      if (if_a.dump_valid !== 0)  begin bad++; $display("FAIL rst_valid: got %0b need 0", if_a.dump_valid); end
      if (done_a !== 0)           begin bad++; $display("FAIL rst_done: got %0b need 0", done_a); end
      if (rsel_a !== 0)           begin bad++; $display("FAIL rst_reg_sel: got %0d need 0", rsel_a); end
      if (cnt_a !== 0)            begin bad++; $display("FAIL rst_count: got %0d need 0", cnt_a); end
      if (cause_a !== 0)          begin bad++; $display("FAIL rst_cause: got %0d need 0", cause_a); end
      if (if_a.dump_idx !== 0)    begin bad++; $display("FAIL rst_idx: got %0d need 0", if_a.dump_idx); end
   endtask

   task automatic test_bp_dump();
      int ecnt, ecause, eid, k; logic [31:0] hpc;
      randomize_rf();
      bp_addr = {32'($urandom), 32'($urandom), 32'($urandom), 32'h48};
      bp_en = 4'b0001; pc_base = 0; loop_len = 0;
      model(1000, ecnt, ecause, eid, hpc);
      launch(0); wait_dump_a();
      total += 5;
      if (cnt_a !== 16'(ecnt))   begin bad++; $display("FAIL bp_count: got %0d need %0d", cnt_a, ecnt); end
      if (cause_a !== 2'(ecause)) begin bad++; $display("FAIL bp_cause: got %0d need %0d", cause_a, ecause); end
      if (bpid_a !== 2'(eid))    begin bad++; $display("FAIL bp_id: got %0d need %0d", bpid_a, eid); end
      if (step_a !== ecnt)       begin bad++; $display("FAIL bp_executed: got %0d need %0d", step_a, ecnt); end
      if (cpu_run_a !== 0)       begin bad++; $display("FAIL bp_frozen: cpu_run=%0b need 0", cpu_run_a); end
      if_a.dump_ready = 1; k = 0;
      for (int n = 0; n < 40 && !done_a; n++) begin
         total += 3;
         if (if_a.dump_idx !== 6'(k)) begin bad++; $display("FAIL dump_idx: got %0d need %0d", if_a.dump_idx, k); end
         if (if_a.dump_data !== exp_word(k, hpc)) begin
            bad++; $display("FAIL dump_data[%0d]: got %h need %h", k, if_a.dump_data, exp_word(k, hpc));
         end
         if (if_a.dump_last !== (k == NREG)) begin bad++; $display("FAIL dump_last[%0d]: got %0b", k, if_a.dump_last); end
         k++;
         @(negedge clk);
      end
      if_a.dump_ready = 0;
      total += 3;
      if (k !== NREG+1)           begin bad++; $display("FAIL dump_words: got %0d need %0d", k, NREG+1); end
      if (done_a !== 1)           begin bad++; $display("FAIL done: got %0b need 1", done_a); end
      if (if_a.dump_valid !== 0)  begin bad++; $display("FAIL done_valid: got %0b need 0", if_a.dump_valid); end
      start_a = 1;
      repeat (3) @(negedge clk);
      start_a = 0;
      total += 3;
      if (done_a !== 1)           begin bad++; $display("FAIL start_in_done: done=%0b need 1", done_a); end
      if (cpu_run_a !== 0)        begin bad++; $display("FAIL start_in_done_run: got %0b need 0", cpu_run_a); end
      if (cause_a !== 2'b01)      begin bad++; $display("FAIL done_cause_held: got %0d need 1", cause_a); end
      pulse_clear();
      total += 2;
      if (done_a !== 0)           begin bad++; $display("FAIL clear_done: got %0b need 0", done_a); end
      if (cnt_a !== 16'(ecnt))    begin bad++; $display("FAIL idle_count_held: got %0d need %0d", cnt_a, ecnt); end
   endtask

   task automatic test_timeout();
      int ecnt, ecause, eid; logic [31:0] hpc;
      bp_en = 0; pc_base = $urandom & 32'hFFFF_FFFC; loop_len = 3;
      model(1000, ecnt, ecause, eid, hpc);
      launch(0); wait_dump_a();
      total += 4;
      if (step_a !== 1000)        begin bad++; $display("FAIL tmo_run_cycles: got %0d need 1000", step_a); end
      if (cnt_a !== 16'(ecnt))    begin bad++; $display("FAIL tmo_count: got %0d need %0d", cnt_a, ecnt); end
      if (cause_a !== 2'(ecause)) begin bad++; $display("FAIL tmo_cause: got %0d need %0d", cause_a, ecause); end
      if (if_a.dump_data !== hpc) begin bad++; $display("FAIL tmo_halt_pc: got %h need %h", if_a.dump_data, hpc); end
      drain_a(); pulse_clear();
   endtask

   task automatic run_bp_case(input string nm);
      int ecnt, ecause, eid; logic [31:0] hpc;
      model(1000, ecnt, ecause, eid, hpc);
      launch(0); wait_dump_a();
      total += 4;
      if (cnt_a !== 16'(ecnt))    begin bad++; $display("FAIL %s_count: got %0d need %0d", nm, cnt_a, ecnt); end
      if (cause_a !== 2'(ecause)) begin bad++; $display("FAIL %s_cause: got %0d need %0d", nm, cause_a, ecause); end
      if (ecause == 1 && bpid_a !== 2'(eid)) begin bad++; $display("FAIL %s_id: got %0d need %0d", nm, bpid_a, eid); end
      if (if_a.dump_data !== hpc) begin bad++; $display("FAIL %s_halt_pc: got %h need %h", nm, if_a.dump_data, hpc); end
      drain_a(); pulse_clear();
   endtask

   task automatic test_multi_bp();
      pc_base = 0; loop_len = 0;
      bp_addr = {32'h10, 32'h10, 32'h10, 32'h400}; bp_en = 4'b1101;
      run_bp_case("multi_lowest");
      bp_addr = {32'h10, 32'h10, 32'h10, 32'h20}; bp_en = 4'b0001;
      run_bp_case("disabled_bp");
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         pc_base  = 32'($urandom_range(0, 15) * 4);
         loop_len = $urandom_range(0, 1) ? $urandom_range(2, 40) : 0;
         for (int k = 0; k < NBP; k++) bp_addr[32*k +: 32] = 32'($urandom_range(0, 80) * 4);
         bp_en = 4'($urandom);
         run_bp_case("random");
      end
   endtask

   task automatic test_backpressure();
      int ecnt, ecause, eid, k; logic [31:0] hpc; bit pat [6] = '{1, 0, 0, 1, 0, 1};
      randomize_rf();
      pc_base = 0; loop_len = 0; bp_addr = {96'h0, 32'h20}; bp_en = 4'b0001;
      model(1000, ecnt, ecause, eid, hpc);
      launch(0); wait_dump_a();
      k = 0;
      for (int n = 0; n < 400 && !done_a; n++) begin
         if_a.dump_ready = (n < 6) ? pat[n] : 1'($urandom_range(0, 1));
         total += 3;
         if (if_a.dump_idx !== 6'(k)) begin bad++; $display("FAIL bp_idx: got %0d need %0d", if_a.dump_idx, k); end
         if (if_a.dump_data !== exp_word(k, hpc)) begin
            bad++; $display("FAIL bp_data[%0d]: got %h need %h", k, if_a.dump_data, exp_word(k, hpc));
         end
         if (if_a.dump_valid !== 1) begin bad++; $display("FAIL bp_valid: got %0b need 1", if_a.dump_valid); end
         if (if_a.dump_ready) k++;
         @(negedge clk);
      end
      if_a.dump_ready = 0;
      total++;
      if (k !== NREG+1) begin bad++; $display("FAIL bp_words: got %0d need %0d", k, NREG+1); end
      pulse_clear();
   endtask

   task automatic test_reset_mid_dump();
      pc_base = 0; loop_len = 0; bp_addr = {96'h0, 32'h30}; bp_en = 4'b0001;
      launch(0); wait_dump_a();
      if_a.dump_ready = 1;
      repeat (7) @(negedge clk);
      if_a.dump_ready = 0;
      total++;
      if (if_a.dump_idx !== 6'd7) begin bad++; $display("FAIL mid_idx: got %0d need 7", if_a.dump_idx); end
      rstn = 0;
      @(negedge clk); rstn = 1;
      total += 5;
      if (if_a.dump_valid !== 0) begin bad++; $display("FAIL mid_rst_valid: got %0b need 0", if_a.dump_valid); end
      if (if_a.dump_idx !== 0)   begin bad++; $display("FAIL mid_rst_idx: got %0d need 0", if_a.dump_idx); end
      if (cause_a !== 0)         begin bad++; $display("FAIL mid_rst_cause: got %0d need 0", cause_a); end
      if (cnt_a !== 0)           begin bad++; $display("FAIL mid_rst_count: got %0d need 0", cnt_a); end
      if (done_a !== 0)          begin bad++; $display("FAIL mid_rst_done: got %0b need 0", done_a); end
      bp_addr = {96'h0, 32'h2C}; bp_en = 4'b0001;
      run_bp_case("after_reset");
   endtask

   task automatic test_tie_budget();
      int ecnt, ecause, eid; logic [31:0] hpc;
      pc_base = 0; loop_len = 0;
      for (int c = 0; c < 2; c++) begin
         bp_addr = {96'h0, 32'h14}; bp_en = (c == 0) ? 4'b0001 : 4'b0000;
         model(5, ecnt, ecause, eid, hpc);
         launch(1);
         for (int n = 0; n < 100 && !done_b; n++) @(negedge clk);
         total += 4;
         if (done_b !== 1)           begin bad++; $display("FAIL tie_done: got %0b need 1", done_b); end
         if (cause_b !== 2'(ecause)) begin bad++; $display("FAIL tie_cause: got %0d need %0d", cause_b, ecause); end
         if (cnt_b !== 16'(ecnt))    begin bad++; $display("FAIL tie_count: got %0d need %0d", cnt_b, ecnt); end
         if (step_b !== ecnt)        begin bad++; $display("FAIL tie_executed: got %0d need %0d", step_b, ecnt); end
         pulse_clear();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rstn = 0; start_a = 0; start_b = 0; clear = 0; cpu_rst = 1;
      bp_addr = '0; bp_en = '0; pc_base = 0; loop_len = 0;
      if_a.dump_ready = 0; if_b.dump_ready = 1;
      for (int i = 0; i < NREG; i++) rf[i] = 32'(i);
      test_reset();
      test_bp_dump();
      test_timeout();
      test_multi_bp();
      test_random();
      test_backpressure();
      test_reset_mid_dump();
      test_tie_budget();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
